// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator with a relation-select output.
// Optional macro SCMP_EARLY_EXIT_EN: finish on the first differing bit instead of always scanning WIDTH bits.
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_mode,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_lt,
  output logic             out_gt,
  output logic             out_eq,
  output logic             out_s
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_mode;
  logic             r_busy;
  logic             r_done;
  logic             r_lt;
  logic             r_gt;
  logic             r_eq;
  logic             r_s;

  logic w_bit_a;
  logic w_bit_b;
  logic w_differ;
  logic w_last;
  logic w_decide;
  logic w_lt;
  logic w_gt;
  logic w_eq;
  logic w_sel;

  assign w_bit_a  = r_a[r_idx];
  assign w_bit_b  = r_b[r_idx];
  assign w_differ = w_bit_a ^ w_bit_b;
  assign w_last   = (r_idx == '0);

`ifdef SCMP_EARLY_EXIT_EN
  assign w_decide = w_differ | w_last;
  assign w_gt     = w_bit_a & ~w_bit_b;
  assign w_lt     = ~w_bit_a & w_bit_b;
  assign w_eq     = ~w_differ;
`else
  // The first differing bit is remembered so the full scan can still report it at index 0.
  logic r_found;
  logic r_first_gt;
  logic w_any;

  assign w_decide = w_last;
  assign w_any    = r_found | w_differ;
  assign w_gt     = r_found ? r_first_gt : (w_bit_a & ~w_bit_b);
  assign w_lt     = w_any & ~w_gt;
  assign w_eq     = ~w_any;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_found    <= 1'b0;
      r_first_gt <= 1'b0;
    end else if (r_state == S_IDLE && in_start) begin
      r_found    <= 1'b0;
      r_first_gt <= 1'b0;
    end else if (r_state == S_RUN && !r_found && w_differ) begin
      r_found    <= 1'b1;
      r_first_gt <= w_bit_a;
    end
  end
`endif

  always_comb begin
    w_sel = 1'b0;
    case (r_mode)
      3'd0:    w_sel = w_lt;
      3'd1:    w_sel = w_gt;
      3'd2:    w_sel = w_eq;
      3'd3:    w_sel = ~w_eq;
      3'd4:    w_sel = w_lt | w_eq;
      3'd5:    w_sel = w_gt | w_eq;
      default: w_sel = 1'b0;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (in_start) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_mode  <= in_mode;
            r_idx   <= IW'(WIDTH - 1);
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_s     <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_decide) begin
            r_lt    <= w_lt;
            r_gt    <= w_gt;
            r_eq    <= w_eq;
            r_s     <= w_sel;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_busy = r_busy;
  assign out_done = r_done;
  assign out_lt   = r_lt;
  assign out_gt   = r_gt;
  assign out_eq   = r_eq;
  assign out_s    = r_s;

endmodule

// File: tb/tb_serial_comparator.sv
// Randomized and directed bench for serial_comparator (WIDTH=8); expectations come from plain arithmetic.
module tb_serial_comparator;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_start;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_mode;
  logic         out_busy;
  logic         out_done;
  logic         out_lt;
  logic         out_gt;
  logic         out_eq;
  logic         out_s;

  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  serial_comparator #(.WIDTH(W)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .in_start (in_start),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_mode  (in_mode),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_lt   (out_lt),
    .out_gt   (out_gt),
    .out_eq   (out_eq),
    .out_s    (out_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: {lt, gt, eq, s}
  function automatic logic [3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] m);
    logic lt, gt, eq, s;
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
    case (m)
      3'd0: s = lt;
      3'd1: s = gt;
      3'd2: s = eq;
      3'd3: s = !eq;
      3'd4: s = (a <= b);
      3'd5: s = (a >= b);
      default: s = 1'b0;
    endcase
    return {lt, gt, eq, s};
  endfunction

  function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    int x;
    x = int'(a ^ b);
    k = -1;
    while (x != 0) begin
      x = x >> 1;
      k++;
    end
`ifdef SCMP_EARLY_EXIT_EN
    return (k < 0) ? W : W - k;
`else
    return W;
`endif
  endfunction

  function automatic logic [3:0] results();
    return {out_lt, out_gt, out_eq, out_s};
  endfunction

  // driver: one comparison, optionally with junk on the inputs while busy
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] m, input bit noise, input string tag);
    int busy_cycles;
    logic [3:0] exp;
    exp_q.push_back(model(a, b, m));
    @(negedge clk);
    in_a = a; in_b = b; in_mode = m; in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    busy_cycles = 0;
    while (out_busy && busy_cycles < 64) begin
      if (busy_cycles == 0)
        check({tag, "_busy_clear"}, {out_done, results()}, 5'b0);
      if (noise) begin
        in_start = 1'($urandom_range(0, 1));
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_mode  = 3'($urandom_range(0, 7));
      end
      busy_cycles++;
      @(negedge clk);
    end
    in_start = 1'b0;
    check({tag, "_latency"}, busy_cycles, latency(a, b));
    check({tag, "_done"}, out_done, 1'b1);
    exp = exp_q.pop_front();
    check({tag, "_result"}, results(), exp);
    @(negedge clk);
    check({tag, "_after"}, {out_busy, out_done}, 2'b00);
    check({tag, "_hold"}, results(), exp);
  endtask

  initial begin
    int cnt;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0; in_start = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {out_busy, out_done, results()}, 6'b0);
    @(posedge clk); #2 rst_n = 1'b1;

    // directed cases
    run_cmp(8'h00, 8'h00, 3'd2, 1'b0, "eq_zero");
    run_cmp(8'h80, 8'h7F, 3'd1, 1'b0, "gt_msb");
    run_cmp(8'h05, 8'h06, 3'd5, 1'b0, "ge_lt");
    run_cmp(8'h05, 8'h06, 3'd3, 1'b0, "ne_lt");
    run_cmp(8'h10, 8'h01, 3'd0, 1'b1, "lt_ignored_start");
    run_cmp(8'hFF, 8'hFF, 3'd5, 1'b0, "ge_eq");
    run_cmp(8'h01, 8'h00, 3'd4, 1'b0, "le_lsb");
    run_cmp(8'hA5, 8'hA5, 3'd6, 1'b0, "reserved6");

    // asynchronous reset mid-RUN
    @(negedge clk);
    in_a = 8'h01; in_b = 8'h00; in_mode = 3'd1; in_start = 1'b1;
    @(negedge clk); in_start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", out_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("reset_async", {out_busy, out_done, results()}, 6'b0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_done) cnt++;
    end
    check("reset_no_done", cnt, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    run_cmp(8'h33, 8'h33, 3'd4, 1'b0, "post_reset");

    // start held high: back-to-back comparisons
    @(negedge clk);
    in_a = 8'h01; in_b = 8'h02; in_mode = 3'd7; in_start = 1'b1;
    cnt = 0;
    while (!out_done && cnt < 64) begin @(negedge clk); cnt++; end
    check("b2b_first_done", out_done, 1'b1);
    check("b2b_first_result", results(), model(8'h01, 8'h02, 3'd7));
    @(negedge clk);
    check("b2b_idle_gap", {out_busy, out_done}, 2'b00);
    cnt = 1;
    while (!out_done && cnt < 64) begin @(negedge clk); cnt++; end
    check("b2b_period", cnt, latency(8'h01, 8'h02) + 2);
    check("b2b_second_result", results(), model(8'h01, 8'h02, 3'd7));
    in_start = 1'b0;
    cnt = 0;
    while ((out_busy || out_done) && cnt < 64) begin @(negedge clk); cnt++; end

    // randomized comparisons
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
